inc_seq: RTL and testbench



---
 rtl/inc_seq_pkg.sv | 10 +
 rtl/inc_seq_add_half.sv | 10 +
 rtl/inc_seq.sv | 110 +++++++++++
 tb/tb_inc_seq.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/inc_seq_pkg.sv
// Shared constants and state encoding for the multi-cycle arithmetic units.
package inc_seq_pkg;
   localparam int INC_WIDTH = 20;
   localparam int INC_CHUNK = 4;

   typedef enum logic {
      INC_IDLE = 1'b0,
      INC_RUN  = 1'b1
   } inc_state_e;
endpackage

// File: rtl/inc_seq_add_half.sv
// One-bit half-adder cell; chained to form the per-cycle slice incrementer.
module add_half (
   input  logic x,
   input  logic cin,
   output logic s,
   output logic cout
);
   assign s    = x ^ cin;
   assign cout = x & cin;
endmodule

// File: rtl/inc_seq.sv
// Multi-cycle ripple incrementer: out = a + 1, one CHUNK-bit slice per RUN cycle,
// optionally stopping once the carry dies out.
module inc_seq
   import inc_seq_pkg::*;
#(
   parameter int WIDTH      = INC_WIDTH,
   parameter int CHUNK      = INC_CHUNK,
   parameter int EARLY_EXIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] out,
   output logic             cout,
   output logic             busy,
   output logic             done
);
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   inc_state_e       state_q, state_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic [IDXW-1:0]  idx_q, idx_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [31:0]      base;
   logic [CHUNK-1:0] slice_in;
   logic [CHUNK-1:0] slice_sum;
   logic [CHUNK:0]   c_chain;
   logic             last_chunk;

   assign base       = 32'(idx_q) * 32'(CHUNK);
   assign slice_in   = out_q[base +: CHUNK];
   assign c_chain[0] = carry_q;
   assign last_chunk = (idx_q == IDXW'(NCHUNK - 1));

   for (genvar g = 0; g < CHUNK; g++) begin : g_ha
      add_half u_ha (
         .x    (slice_in[g]),
         .cin  (c_chain[g]),
         .s    (slice_sum[g]),
         .cout (c_chain[g+1])
      );
   end

   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         INC_IDLE: begin
            if (start) begin
               out_d   = a;
               carry_d = 1'b1;
               idx_d   = '0;
               cout_d  = 1'b0;
               busy_d  = 1'b1;
               state_d = INC_RUN;
            end
         end
         INC_RUN: begin
            out_d[base +: CHUNK] = slice_sum;
            carry_d              = c_chain[CHUNK];
            // Upper slices still hold a, so stopping on a dead carry is exact.
            if (last_chunk || ((EARLY_EXIT != 0) && !c_chain[CHUNK])) begin
               cout_d  = last_chunk & c_chain[CHUNK];
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = INC_IDLE;
            end else begin
               idx_d = idx_q + IDXW'(1);
            end
         end
         default: state_d = INC_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= INC_IDLE;
         out_q   <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign out  = out_q;
   assign cout = cout_q;
   assign busy = busy_q;
   assign done = done_q;
endmodule

// File: tb/tb_inc_seq.sv
// Directed and random checks of inc_seq: results, carry-out, latency, handshake, reset.
module tb_inc_seq;
   logic        clk = 1'b0;
   logic        rst;
   logic        start1, start2;
   logic [19:0] a1, a2;
   logic [19:0] out1, out2;
   logic        cout1, cout2, busy1, busy2, done1, done2;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   inc_seq #(.WIDTH(20), .CHUNK(4), .EARLY_EXIT(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .a(a1),
      .out(out1), .cout(cout1), .busy(busy1), .done(done1)
   );

   inc_seq #(.WIDTH(20), .CHUNK(4), .EARLY_EXIT(0)) u_dut2 (
      .clk(clk), .rst(rst), .start(start2), .a(a2),
      .out(out2), .cout(cout2), .busy(busy2), .done(done2)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Edges from the accept edge (inclusive) until done is seen; busy cycles counted too.
   task automatic run1(input logic [19:0] av, output int lat, output int nbusy);
      a1     = av;
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      lat    = 1;
      nbusy  = 0;
      while (!done1 && lat < 20) begin
         if (busy1) nbusy++;
         tick();
         lat++;
      end
   endtask

   function automatic int exp_lat(input logic [19:0] v);
      for (int i = 0; i < 5; i++) begin
         logic [3:0] nib;
         nib = v[i*4 +: 4];
         if (nib != 4'hF) return i + 2;
      end
      return 6;
   endfunction

   task automatic check_op(input string tag, input logic [19:0] av);
      int lat, nb;
      logic [19:0] expv;
      expv = av + 20'd1;
      run1(av, lat, nb);
      chk({tag, "_out"}, 32'(out1), 32'(expv));
      chk({tag, "_cout"}, 32'(cout1), 32'(av == 20'hFFFFF));
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat(av)));
   endtask

   initial begin
      int lat, nb, nd;
      logic [19:0] v;

      rst = 1'b1; start1 = 1'b0; start2 = 1'b0; a1 = '0; a2 = '0;
      tick(); tick();
      chk("rst_out", 32'(out1), 32'h0);
      chk("rst_cout", 32'(cout1), 32'h0);
      chk("rst_busy", 32'(busy1), 32'h0);
      chk("rst_done", 32'(done1), 32'h0);
      rst = 1'b0;
      tick();

      // 1: zero operand, single RUN cycle
      run1(20'h00000, lat, nb);
      chk("t1_lat", 32'(lat), 32'd2);
      chk("t1_out", 32'(out1), 32'h00001);
      chk("t1_cout", 32'(cout1), 32'h0);
      chk("t1_busy_cycles", 32'(nb), 32'd1);
      tick();
      chk("t1_done_pulse", 32'(done1), 32'h0);
      chk("t1_out_hold", 32'(out1), 32'h00001);

      // 2: all ones wraps
      run1(20'hFFFFF, lat, nb);
      chk("t2_lat", 32'(lat), 32'd6);
      chk("t2_out", 32'(out1), 32'h00000);
      chk("t2_cout", 32'(cout1), 32'h1);
      chk("t2_busy_cycles", 32'(nb), 32'd5);

      // 3
      run1(20'h000FF, lat, nb);
      chk("t3_lat", 32'(lat), 32'd4);
      chk("t3_out", 32'(out1), 32'h00100);
      chk("t3_cout", 32'(cout1), 32'h0);

      // 4: start while busy is ignored
      a1 = 20'h000FF; start1 = 1'b1;
      tick();
      start1 = 1'b0;
      tick();
      a1 = 20'h12345; start1 = 1'b1;
      tick();
      start1 = 1'b0;
      nd = 0;
      for (int i = 0; i < 6; i++) begin
         if (done1) nd++;
         tick();
      end
      chk("t4_done_count", 32'(nd), 32'd1);
      chk("t4_out", 32'(out1), 32'h00100);
      chk("t4_busy", 32'(busy1), 32'h0);

      // 5: async reset mid-operation
      a1 = 20'hFFFFF; start1 = 1'b1;
      tick();
      start1 = 1'b0;
      tick(); tick();
      rst = 1'b1;
      #1;
      chk("t5_rst_out", 32'(out1), 32'h0);
      chk("t5_rst_busy", 32'(busy1), 32'h0);
      chk("t5_rst_cout", 32'(cout1), 32'h0);
      chk("t5_rst_done", 32'(done1), 32'h0);
      #2;
      rst = 1'b0;
      nd = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (done1) nd++;
      end
      chk("t5_no_done", 32'(nd), 32'd0);
      run1(20'h0000F, lat, nb);
      chk("t5_lat", 32'(lat), 32'd3);
      chk("t5_out", 32'(out1), 32'h00010);

      // 6: no early exit, back-to-back with start held
      a2 = 20'h00000; start2 = 1'b1;
      tick();
      a2 = 20'h00005;
      lat = 1;
      while (!done2 && lat < 20) begin
         tick();
         lat++;
      end
      chk("t6_lat", 32'(lat), 32'd6);
      chk("t6_out", 32'(out2), 32'h00001);
      tick();
      start2 = 1'b0;
      chk("t6_b2b_busy", 32'(busy2), 32'h1);
      chk("t6_b2b_done", 32'(done2), 32'h0);
      chk("t6_b2b_capture", 32'(out2), 32'h00005);
      lat = 1;
      while (!done2 && lat < 20) begin
         tick();
         lat++;
      end
      chk("t6_b2b_lat", 32'(lat), 32'd6);
      chk("t6_b2b_out", 32'(out2), 32'h00006);
      chk("t6_b2b_cout", 32'(cout2), 32'h0);

      // all-ones in each slice, alone and with all lower slices
      for (int s = 0; s < 5; s++) begin
         v = 20'hF << (4 * s);
         check_op($sformatf("slice%0d", s), v);
         v = 20'((21'd1 << (4 * (s + 1))) - 21'd1);
         check_op($sformatf("low%0d", s), v);
      end

      for (int i = 0; i < 1000; i++) begin
         v = 20'($urandom);
         if (i % 4 == 0) v = v | 20'h000FF;
         check_op("rnd", v);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
